uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Serialises LSB-first frames with configurable data width, optional even/odd parity and 1 or 2 stop bits. A valid/ready handshake and a one-entry holding buffer allow frames to be sent back-to-back with no idle gap. It sits between a byte producer (CPU register, FIFO) and the TX pin.

Parameters:
CLKS_PER_BIT, 87, i_clk cycles per bit period; legal values are 2 or more.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, when PARITY_EN=1: 0 selects even parity, 1 selects odd parity.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
i_clk  input  1  system clock; all logic is on the rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_tx_dv  input  1  producer valid; a word is accepted on any edge where i_tx_dv && o_tx_ready.
i_tx_byte  input  DATA_BITS  data word; sampled at acceptance.
o_tx_ready  output  1  high when the holding buffer is empty.
o_tx_serial  output  1  serial line, registered, idles high.
o_tx_active  output  1  high while any frame bit is being driven.
o_tx_done  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset (async assert, sync release): o_tx_serial=1, o_tx_ready=1, o_tx_active=0, o_tx_done=0. State IDLE; buffer empty; all counters 0. Reset asserted mid-frame aborts the frame immediately: line goes high and the buffered word is discarded.
- Frame format: START(0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1). Frame length is 1+DATA_BITS+PARITY_EN+STOP_BITS bit periods.
- Every bit is held for exactly CLKS_PER_BIT cycles. Bit counter width is $clog2(CLKS_PER_BIT). The counter runs 0..CLKS_PER_BIT-1; the bit advances when the count reaches CLKS_PER_BIT-1.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START when a word is available.
  - START→DATA after 1 bit period.
  - DATA→PARITY (PARITY_EN=1) or DATA→STOP after DATA_BITS periods.
  - PARITY→STOP after 1 period.
  - STOP→START if the buffer is full, otherwise STOP→IDLE, after STOP_BITS periods.
- Parity: even parity = XOR of the data bits. Odd parity = inverted XOR. Parity is computed from the word latched in the shift register, not from the live input.
- Acceptance in IDLE with the buffer empty: the word loads directly into the shift register and the state becomes START on the same edge. o_tx_serial=0 from the next cycle, giving 1-cycle latency. o_tx_ready stays 1.
- Acceptance while active: the word goes to the holding buffer and o_tx_ready drops to 0 on the following cycle.
- At the final cycle of the last stop bit:
  - o_tx_done pulses high for exactly 1 cycle.
  - If the buffer is full, the buffered word moves to the shift register and the line goes low on the next cycle, with no idle bit between frames. The buffer empties and o_tx_ready rises on that same edge.
- o_tx_active is high from the first START cycle through the last STOP cycle. It stays continuously high across back-to-back frames.
- If i_tx_dv is asserted while o_tx_ready=0, the word is ignored and nothing is corrupted. The producer must hold the word until it is accepted.
- A frame end and a new i_tx_dv in the same cycle with the buffer full: the new word is not accepted that cycle; it is accepted on the next cycle because ready has risen.
- Changes on i_tx_byte after acceptance have no effect on the frame in flight.

Test Plan:
1. Reset: hold i_rst_n=0 for 5 cycles, then release. Required: o_tx_serial=1, o_tx_ready=1, o_tx_active=0, o_tx_done=0 throughout.
2. Default config, CLKS_PER_BIT=4: send 8'hA5. Required: line reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; serial low 1 cycle after acceptance; o_tx_done high for 1 cycle at cycle 40 of the frame.
3. DATA_BITS=7, PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2: send 7'h53 (four ones). Required: parity bit=0 and 11 bit periods. Rerun with PARITY_ODD=1: parity bit=1.
4. Back-to-back: present 8'h01 then immediately 8'hFF. Required: second word buffered and o_tx_ready=0; the second START follows the first STOP with no gap; o_tx_active stays high continuously; two o_tx_done pulses 10 bit periods apart.
5. Stall: with the buffer full, hold i_tx_dv with 8'h3C. Required: 8'h3C is not accepted until o_tx_ready rises, then it is transmitted as the third frame unaltered.
6. Reset mid-frame: assert i_rst_n=0 during DATA bit 3 with a buffered word. Required: o_tx_serial=1 and o_tx_active=0 immediately; after release, no frame is transmitted until a new i_tx_dv.

Source files
------------

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//   Parametrised UART transmitter. Serialises LSB-first frames made of a start
//   bit, DATA_BITS data bits, an optional even/odd parity bit and 1 or 2 stop
//   bits. A one-entry holding buffer behind a valid/ready handshake lets a
//   producer queue the next word while a frame is on the line, so consecutive
//   frames go out with no idle bit between them.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_tx_dv      producer valid; word accepted when i_tx_dv && o_tx_ready
//   i_tx_byte    data word (DATA_BITS wide), sampled at acceptance
//   o_tx_ready   high while the holding buffer is empty
//   o_tx_serial  registered serial line, idles high
//   o_tx_active  high from the first start cycle through the last stop cycle
//   o_tx_done    one-cycle pulse during the final cycle of each frame
// -----------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_tx_dv,
    input  logic [DATA_BITS-1:0] i_tx_byte,
    output logic                 o_tx_ready,
    output logic                 o_tx_serial,
    output logic                 o_tx_active,
    output logic                 o_tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic             PAR_INV   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     clk_cnt;
    logic [3:0]           bit_idx;     // data-bit index in DATA, stop-bit index in STOP
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] hold_q;
    logic                 hold_full;
    logic                 parity_q;
    logic                 serial_q;
    logic                 active_q;
    logic                 done_q;

    logic accept;
    logic bit_end;

    assign accept  = i_tx_dv && !hold_full;
    assign bit_end = (clk_cnt == CNT_LAST);

    assign o_tx_ready  = !hold_full;
    assign o_tx_serial = serial_q;
    assign o_tx_active = active_q;
    assign o_tx_done   = done_q;

    // NOTE: every register below is assigned with <= so all of them update
    // from the same pre-edge values; with = the state, counter and buffer
    // decisions would see half-updated values depending on statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the data registers are reset too, not just the control
            // state, so an aborted frame leaves nothing stale behind.
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift_q   <= '0;
            hold_q    <= '0;
            hold_full <= 1'b0;
            parity_q  <= 1'b0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Any word accepted outside IDLE is queued; in IDLE it bypasses
            // the buffer. hold_full cannot be cleared below on an edge where
            // accept is high, because accept requires the buffer empty.
            if (accept && state != IDLE) begin
                hold_q    <= i_tx_byte;
                hold_full <= 1'b1;
            end

            if (state != IDLE)
                clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (hold_full) begin
                        shift_q   <= hold_q;
                        hold_full <= 1'b0;
                        state     <= START;
                        serial_q  <= 1'b0;
                        active_q  <= 1'b1;
                    end else if (i_tx_dv) begin
                        shift_q  <= i_tx_byte;
                        state    <= START;
                        serial_q <= 1'b0;
                        active_q <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        // Parity comes from the latched word before shifting.
                        parity_q <= (^shift_q) ^ PAR_INV;
                        serial_q <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                state    <= PARITY;
                                serial_q <= parity_q;
                            end else begin
                                state    <= STOP;
                                serial_q <= 1'b1;
                            end
                        end else begin
                            serial_q <= shift_q[0];
                            shift_q  <= shift_q >> 1;
                            bit_idx  <= bit_idx + 1'b1;
                        end
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        serial_q <= 1'b1;
                    end
                end

                STOP: begin
                    // Raised one cycle early so the registered pulse lands on
                    // the final cycle of the last stop bit.
                    if (bit_idx == STOP_LAST && clk_cnt == CNT_PRE)
                        done_q <= 1'b1;

                    if (bit_end) begin
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            if (hold_full) begin
                                shift_q   <= hold_q;
                                hold_full <= 1'b0;
                                state     <= START;
                                serial_q  <= 1'b0;
                            end else begin
                                state    <= IDLE;
                                serial_q <= 1'b1;
                                active_q <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    serial_q <= 1'b1;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
//   Directed bench for uart_tx_frame. Three instances share clock and reset:
//   u_a is 8N1, u_e is 7 data bits / even parity / 2 stop, u_o is the same with
//   odd parity. All bit periods are 4 clocks. Inputs are driven and outputs
//   sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

    localparam int CPB = 4;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b1;

    logic       a_dv, a_ready, a_serial, a_active, a_done;
    logic [7:0] a_byte;
    logic       e_dv, e_ready, e_serial, e_active, e_done;
    logic [6:0] e_byte;
    logic       o_dv, o_ready, o_serial, o_active, o_done;
    logic [6:0] o_byte;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 i_clk = ~i_clk;

    uart_tx_frame #(.CLKS_PER_BIT(CPB)) u_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tx_dv(a_dv), .i_tx_byte(a_byte),
        .o_tx_ready(a_ready), .o_tx_serial(a_serial),
        .o_tx_active(a_active), .o_tx_done(a_done)
    );

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(1),
                    .PARITY_ODD(0), .STOP_BITS(2)) u_e (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tx_dv(e_dv), .i_tx_byte(e_byte),
        .o_tx_ready(e_ready), .o_tx_serial(e_serial),
        .o_tx_active(e_active), .o_tx_done(e_done)
    );

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(1),
                    .PARITY_ODD(1), .STOP_BITS(2)) u_o (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tx_dv(o_dv), .i_tx_byte(o_byte),
        .o_tx_ready(o_ready), .o_tx_serial(o_serial),
        .o_tx_active(o_active), .o_tx_done(o_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sample(input int sel, output logic s, output logic ac,
                          output logic d, output logic r);
        case (sel)
            0:       begin s = a_serial; ac = a_active; d = a_done; r = a_ready; end
            1:       begin s = e_serial; ac = e_active; d = e_done; r = e_ready; end
            default: begin s = o_serial; ac = o_active; d = o_done; r = o_ready; end
        endcase
    endtask

    // Follows one isolated frame cycle by cycle, starting on the edge that
    // accepts the word. The input word is scrambled right after acceptance.
    task automatic watch(input int sel, input string tag, input logic [15:0] line,
                         input int nbits);
        logic s, ac, d, r;
        for (int k = 1; k <= nbits * CPB; k++) begin
            cyc();
            if (k == 1) begin
                a_dv = 1'b0; e_dv = 1'b0; o_dv = 1'b0;
                a_byte = 8'h00; e_byte = 7'h7F; o_byte = 7'h00;
            end
            sample(sel, s, ac, d, r);
            check($sformatf("%s serial c%0d", tag, k), s, line[(k-1)/CPB]);
            check($sformatf("%s active c%0d", tag, k), ac, 1'b1);
            check($sformatf("%s done c%0d", tag, k), d, (k == nbits * CPB));
            if (k == 1)
                check($sformatf("%s ready c1", tag), r, 1'b1);
        end
        cyc();
        sample(sel, s, ac, d, r);
        check($sformatf("%s idle after", tag), {s, ac, d, r}, 4'b1001);
    endtask

    initial begin
        logic       s, ac, d, r;
        logic [7:0] w;
        logic       exp_s;
        int         f, pos;

        a_dv = 1'b0; e_dv = 1'b0; o_dv = 1'b0;
        a_byte = '0; e_byte = '0; o_byte = '0;

        // 1. Reset held for 5 cycles, then released.
        #2 i_rst_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("rst a outs", {a_serial, a_ready, a_active, a_done}, 4'b1100);
            check("rst e/o outs", {e_serial, e_active, o_serial, o_active}, 4'b1010);
        end
        i_rst_n = 1'b1;
        cyc();
        check("post rst a outs", {a_serial, a_ready, a_active, a_done}, 4'b1100);

        // 2. 8N1, 0xA5: line 0,1,0,1,0,0,1,0,1,1 (bit 0 first).
        a_byte = 8'hA5; a_dv = 1'b1;
        watch(0, "a5", 16'b0000_0011_0100_1010, 10);

        // 3. 7E2 / 7O2 with 0x53 (four ones): parity 0 then 1, 11 periods.
        e_byte = 7'h53; e_dv = 1'b1;
        watch(1, "par_even", 16'b0000_0110_1010_0110, 11);
        o_byte = 7'h53; o_dv = 1'b1;
        watch(2, "par_odd", 16'b0000_0111_1010_0110, 11);

        // 4/5. Back-to-back 0x01, 0xFF, then 0x3C held while stalled.
        a_byte = 8'h01; a_dv = 1'b1;
        for (int k = 1; k <= 121; k++) begin
            cyc();
            if (k == 1) a_byte = 8'hFF;
            if (k == 2) a_byte = 8'h3C;
            if (k == 42) begin a_dv = 1'b0; a_byte = 8'h00; end
            sample(0, s, ac, d, r);
            if (k <= 120) begin
                f   = (k - 1) / 40;
                pos = ((k - 1) % 40) / CPB;
                w   = (f == 0) ? 8'h01 : (f == 1) ? 8'hFF : 8'h3C;
                exp_s = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : w[pos-1];
            end else begin
                exp_s = 1'b1;
            end
            check($sformatf("b2b serial c%0d", k), s, exp_s);
            check($sformatf("b2b active c%0d", k), ac, (k <= 120));
            check($sformatf("b2b done c%0d", k), d, (k == 40 || k == 80 || k == 120));
            check($sformatf("b2b ready c%0d", k), r, (k == 1 || k == 41 || k >= 81));
        end

        // 6. Reset during data bit 3 with a word buffered.
        a_byte = 8'h55; a_dv = 1'b1;
        cyc();
        a_byte = 8'h0F;
        cyc();
        a_dv = 1'b0;
        check("mid buffered ready", a_ready, 1'b0);
        repeat (16) cyc();
        check("mid data bit3", {a_serial, a_active}, 2'b01);
        i_rst_n = 1'b0;
        #1;
        check("mid rst outs", {a_serial, a_ready, a_active, a_done}, 4'b1100);
        repeat (3) cyc();
        i_rst_n = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            cyc();
            check($sformatf("post abort c%0d", k), {a_serial, a_active, a_ready}, 3'b101);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
